// File: rtl/reg_display_sequencer_pkg.sv
// Shared constants for the register display path feeding the HEX digit decoders.
package reg_display_sequencer_pkg;

    localparam int NIBBLE_W                = 4;
    localparam int DIGITS                  = 4;
    localparam int REG_W                   = NIBBLE_W * DIGITS;
    localparam int SEL_W                   = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_SCROLL_CYCLES   = 50000000;

    function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [REG_W-1:0] word,
                                                      input int unsigned k);
        return word[k*NIBBLE_W +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, stability counter and
// a single-cycle pulse on an accepted press (release is silent).
module button_debouncer
    import reg_display_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, count how long the input disagrees with the accepted level, accept when stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            press_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_MAX) begin
                level_r <= sync2_r;
                cnt_r   <= {CNT_W{1'b0}};
                press_r <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/reg_display_sequencer.sv
// Picks one register from the register-file tap and presents it as four registered
// nibbles plus its index; selection advances on a debounced press or auto-scroll tick.
module reg_display_sequencer
    import reg_display_sequencer_pkg::*;
#(
    parameter int NUM_REGS        = 8,
    parameter int DATA_W          = REG_W,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SCROLL_CYCLES   = DEFAULT_SCROLL_CYCLES
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic [NUM_REGS*DATA_W-1:0] RegFile,
    input  logic                       Step_n,
    input  logic                       Auto,
    input  logic                       Freeze,
    output logic [3:0]                 Nib0,
    output logic [3:0]                 Nib1,
    output logic [3:0]                 Nib2,
    output logic [3:0]                 Nib3,
    output logic [3:0]                 RegIdx,
    output logic                       Update
);

    localparam int SCW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
    localparam logic [SCW-1:0]   SCROLL_MAX = SCW'(SCROLL_CYCLES - 1);
    localparam logic [SCW-1:0]   SCROLL_ONE = SCW'(1);
    localparam logic [SEL_W-1:0] SEL_MAX    = SEL_W'(NUM_REGS - 1);
    localparam logic [SEL_W-1:0] SEL_ONE    = SEL_W'(1);

    logic              auto_s1_r;
    logic              auto_sync_r;
    logic              freeze_s1_r;
    logic              freeze_sync_r;
    logic              press_s;
    logic              scroll_tick_s;
    logic [SCW-1:0]    scroll_cnt_r;
    logic [SEL_W-1:0]  sel_r;
    logic              loaded_r;
    logic [DATA_W-1:0] word_s;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debouncer (
        .clk  (Clock),
        .rst_n(Reset_n),
        .btn_n(Step_n),
        .press(press_s)
    );

    // Two-flop synchronizers for the slide switches.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            auto_s1_r     <= 1'b0;
            auto_sync_r   <= 1'b0;
            freeze_s1_r   <= 1'b0;
            freeze_sync_r <= 1'b0;
        end else begin
            auto_s1_r     <= Auto;
            auto_sync_r   <= auto_s1_r;
            freeze_s1_r   <= Freeze;
            freeze_sync_r <= freeze_s1_r;
        end
    end

    // Scroll tick fires on the last count of the period while auto-scroll is on.
    always_comb begin
        if (auto_sync_r && (scroll_cnt_r == SCROLL_MAX)) begin
            scroll_tick_s = 1'b1;
        end else begin
            scroll_tick_s = 1'b0;
        end
    end

    // Auto-scroll period counter; a manual press restarts the period.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            scroll_cnt_r <= {SCW{1'b0}};
        end else if (!auto_sync_r || press_s || scroll_cnt_r == SCROLL_MAX) begin
            scroll_cnt_r <= {SCW{1'b0}};
        end else begin
            scroll_cnt_r <= scroll_cnt_r + SCROLL_ONE;
        end
    end

    // Selection advances once per cycle even if press and tick coincide.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_r <= {SEL_W{1'b0}};
        end else if (press_s || scroll_tick_s) begin
            sel_r <= (sel_r == SEL_MAX) ? {SEL_W{1'b0}} : sel_r + SEL_ONE;
        end else begin
            sel_r <= sel_r;
        end
    end

    // AND-OR mux of the selected register out of the flattened tap.
    always_comb begin
        word_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            word_s = word_s | (RegFile[i*DATA_W +: DATA_W] & {DATA_W{sel_r == SEL_W'(i)}});
        end
    end

    // Output stage: tracks the live register unless frozen; first load after reset also pulses Update.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Nib0     <= 4'h0;
            Nib1     <= 4'h0;
            Nib2     <= 4'h0;
            Nib3     <= 4'h0;
            RegIdx   <= 4'h0;
            Update   <= 1'b0;
            loaded_r <= 1'b0;
        end else if (freeze_sync_r) begin
            Update <= 1'b0;
        end else begin
            Nib0     <= nibble_of(word_s, 0);
            Nib1     <= nibble_of(word_s, 1);
            Nib2     <= nibble_of(word_s, 2);
            Nib3     <= nibble_of(word_s, 3);
            RegIdx   <= sel_r;
            Update   <= ~loaded_r | (sel_r != RegIdx);
            loaded_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_display_sequencer.sv
// Scoreboard bench: stimulus queues expected display loads, a negedge monitor checks each Update.
module tb_reg_display_sequencer;

    localparam int NR = 8;

    logic            Clock = 1'b0;
    logic            Reset_n;
    logic [NR*16-1:0] RegFile;
    logic            Step_n;
    logic            Auto;
    logic            Freeze;
    logic [3:0]      Nib0, Nib1, Nib2, Nib3, RegIdx;
    logic            Update;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] data;
        logic [31:0] at;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    reg_display_sequencer #(
        .NUM_REGS(NR), .DATA_W(16), .DEBOUNCE_CYCLES(4), .SCROLL_CYCLES(10)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .RegFile(RegFile), .Step_n(Step_n),
        .Auto(Auto), .Freeze(Freeze), .Nib0(Nib0), .Nib1(Nib1), .Nib2(Nib2),
        .Nib3(Nib3), .RegIdx(RegIdx), .Update(Update)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic expect_upd(input int idx, input int at);
        exp_t e;
        e.idx  = 4'(idx);
        e.data = 16'hA0B0 + 16'(idx);
        e.at   = 32'(at);
        sb.push_back(e);
    endtask

    task automatic expect_upd_data(input int idx, input logic [15:0] data, input int at);
        exp_t e;
        e.idx  = 4'(idx);
        e.data = data;
        e.at   = 32'(at);
        sb.push_back(e);
    endtask

    // Monitor: every Update must match the oldest expected display load.
    always @(negedge Clock) begin
        if (Reset_n === 1'b1 && Update === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_update: got idx %0d at cycle %0d want no update", RegIdx, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_idx", 32'(RegIdx), 32'(e.idx));
                check("upd_data", 32'({Nib3, Nib2, Nib1, Nib0}), 32'(e.data));
                check("upd_cycle", 32'(cyc), e.at);
            end
        end
    end

    initial begin
        int a;
        Reset_n = 1'b0;
        Step_n  = 1'b1;
        Auto    = 1'b0;
        Freeze  = 1'b0;
        for (int i = 0; i < NR; i++) RegFile[i*16 +: 16] = 16'hA0B0 + 16'(i);
        wait_cycles(3);
        check("reset_nibs", 32'({Nib3, Nib2, Nib1, Nib0}), 32'h0);
        check("reset_idx", 32'(RegIdx), 32'h0);
        check("reset_update", 32'(Update), 32'h0);

        // First load after reset pulses Update once with register 0.
        Reset_n = 1'b1;
        expect_upd(0, cyc + 1);
        wait_cycles(10);

        // Clean press: 2 sync + 4 debounce + 1 sel + 1 output.
        Step_n = 1'b0;
        expect_upd(1, cyc + 8);
        wait_cycles(8);
        Step_n = 1'b1;
        wait_cycles(12);
        check("step_idx", 32'(RegIdx), 32'h1);

        // Bounces: the 3-cycle low reaches count 3 but never gets accepted.
        Step_n = 1'b0; wait_cycles(2);
        Step_n = 1'b1; wait_cycles(1);
        Step_n = 1'b0; wait_cycles(3);
        Step_n = 1'b1; wait_cycles(15);
        check("glitch_idx", 32'(RegIdx), 32'h1);

        // Auto-scroll: eight ticks, wrapping 7 -> 0.
        a = cyc;
        Auto = 1'b1;
        for (int k = 1; k <= 8; k++) expect_upd((1 + k) % NR, a + 3 + 10 * k);
        wait_cycles(85);
        Auto = 1'b0;
        wait_cycles(15);
        check("auto_idx", 32'(RegIdx), 32'h1);

        // Press lands in the same cycle as the second tick: one increment only.
        a = cyc;
        Auto = 1'b1;
        expect_upd(2, a + 13);
        expect_upd(3, a + 23);
        expect_upd(4, a + 33);
        wait_cycles(15);
        Step_n = 1'b0;
        wait_cycles(8);
        Step_n = 1'b1;
        wait_cycles(12);
        Auto = 1'b0;
        wait_cycles(15);
        check("coincide_idx", 32'(RegIdx), 32'h4);

        // Freeze: outputs hold through a live data change and two presses.
        Freeze = 1'b1;
        wait_cycles(5);
        RegFile[4*16 +: 16] = 16'h1234;
        wait_cycles(2);
        check("freeze_data", 32'({Nib3, Nib2, Nib1, Nib0}), 32'hA0B4);
        for (int s = 0; s < 2; s++) begin
            Step_n = 1'b0; wait_cycles(8);
            Step_n = 1'b1; wait_cycles(10);
        end
        check("freeze_idx", 32'(RegIdx), 32'h4);
        check("freeze_data2", 32'({Nib3, Nib2, Nib1, Nib0}), 32'hA0B4);
        Freeze = 1'b0;
        expect_upd(6, cyc + 3);
        wait_cycles(6);
        check("unfreeze_idx", 32'(RegIdx), 32'h6);

        // Live tracking without a selection change: new data, no Update.
        RegFile[6*16 +: 16] = 16'h5A5A;
        wait_cycles(1);
        check("live_data", 32'({Nib3, Nib2, Nib1, Nib0}), 32'h5A5A);
        check("live_no_update", 32'(Update), 32'h0);
        RegFile[4*16 +: 16] = 16'hA0B4;
        RegFile[6*16 +: 16] = 16'hA0B6;
        wait_cycles(1);
        expect_upd_data(6, 16'hA0B6, -1);
        void'(sb.pop_back());

        // Asynchronous reset in the middle of a debounce.
        Step_n = 1'b0;
        wait_cycles(4);
        #2 Reset_n = 1'b0;
        #1;
        check("async_reset_idx", 32'(RegIdx), 32'h0);
        check("async_reset_nibs", 32'({Nib3, Nib2, Nib1, Nib0}), 32'h0);
        check("async_reset_update", 32'(Update), 32'h0);
        Step_n = 1'b1;
        wait_cycles(2);
        Reset_n = 1'b1;
        expect_upd(0, cyc + 1);
        wait_cycles(20);
        check("post_reset_idx", 32'(RegIdx), 32'h0);

        wait_cycles(2);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
